mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the burst memory access controller.
package mem_access_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_BEAT    = 3'd1,
        RD_ISSUE   = 3'd2,
        RD_CAPTURE = 3'd3,
        RD_OUT     = 3'd4,
        DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Burst controller between a valid/ready host port and a single-port synchronous memory.
// Writes go straight through one beat per accepted wdata; reads take issue/capture/output cycles.
module mem_access_ctrl #(
    parameter int ADDR_W = mem_access_ctrl_pkg::ADDR_W,
    parameter int DATA_W = mem_access_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_access_ctrl_pkg::*;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                beat_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        beat_done      = 1'b0;
        req_ready      = 1'b0;
        wdata_ready    = 1'b0;
        rdata_valid    = 1'b0;
        done           = 1'b0;
        mem_enable     = 1'b0;
        mem_read_write = 1'b1;
        mem_wdata      = '0;
        mem_addr       = addr_reg;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_next  = req_addr;
                    cnt_next   = req_len;
                    state_next = req_write ? WR_BEAT : RD_ISSUE;
                end
            end
            WR_BEAT: begin
                wdata_ready = wdata_valid;
                if (wdata_valid) begin
                    mem_enable     = 1'b1;
                    mem_read_write = 1'b0;
                    mem_wdata      = wdata;
                    beat_done      = 1'b1;
                end
            end
            RD_ISSUE: begin
                mem_enable = 1'b1;
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                rdata_next = mem_rdata;
                state_next = RD_OUT;
            end
            RD_OUT: begin
                rdata_valid = 1'b1;
                beat_done   = rdata_ready;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Shared beat bookkeeping for both directions; address wraps silently.
        if (beat_done) begin
            addr_next = addr_reg + 1'b1;
            if (cnt_reg == '0) begin
                state_next = DONE;
            end else begin
                cnt_next   = cnt_reg - 1'b1;
                state_next = (state_reg == WR_BEAT) ? WR_BEAT : RD_ISSUE;
            end
        end

        // Asserted reset masks the outputs at once so an interrupted burst
        // cannot commit one more beat on the reset edge itself.
        if (!rst_n) begin
            req_ready      = 1'b1;
            wdata_ready    = 1'b0;
            rdata_valid    = 1'b0;
            done           = 1'b0;
            mem_enable     = 1'b0;
            mem_read_write = 1'b1;
            mem_wdata      = '0;
            mem_addr       = '0;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: controller paired with a behavioural 16x8 synchronous memory.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_write;
    logic       req_ready;
    logic [3:0] req_addr, req_len;
    logic [7:0] wdata;
    logic       wdata_valid, wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid, rdata_ready;
    logic       done;
    logic [3:0] mem_addr;
    logic       mem_enable, mem_read_write;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] mem [16];
    int compared = 0;
    int mismatched = 0;
    int wr_count = 0;
    int rd_count = 0;
    int done_count = 0;
    int snap_wr, snap_rd, snap_done;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .done(done), .mem_addr(mem_addr), .mem_enable(mem_enable),
        .mem_read_write(mem_read_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // 16x8 memory: write commits and read data registers on the enabled edge.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_read_write) begin
                mem_rdata <= mem[mem_addr];
                rd_count  <= rd_count + 1;
            end else begin
                mem[mem_addr] <= mem_wdata;
                wr_count      <= wr_count + 1;
            end
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic [3:0] a, input logic [3:0] l);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        #1;
        check("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic write_beat(input logic [3:0] a, input logic [7:0] d);
        wdata = d; wdata_valid = 1'b1;
        #1;
        check("wr_enable", mem_enable, 1);
        check("wr_rw", mem_read_write, 0);
        check("wr_addr", mem_addr, a);
        check("wr_data", mem_wdata, d);
        check("wr_ready", wdata_ready, 1);
        step();
        wdata_valid = 1'b0;
    endtask

    task automatic read_beat(input logic [3:0] a, input logic [7:0] d);
        #1;
        check("rd_issue_en", mem_enable, 1);
        check("rd_issue_rw", mem_read_write, 1);
        check("rd_issue_addr", mem_addr, a);
        check("rd_issue_valid", rdata_valid, 0);
        step();
        check("rd_cap_en", mem_enable, 0);
        check("rd_cap_valid", rdata_valid, 0);
        step();
        rdata_ready = 1'b1;
        #1;
        check("rd_out_valid", rdata_valid, 1);
        check("rd_out_data", rdata, d);
        step();
        rdata_ready = 1'b0;
    endtask

    task automatic finish_burst();
        #1;
        check("done_pulse", done, 1);
        check("done_no_enable", mem_enable, 0);
        step();
        check("done_cleared", done, 0);
        check("idle_ready", req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_len = 4'h0;
        wdata = 8'hFF; wdata_valid = 1'b1; rdata_ready = 1'b0;

        // Reset state, with wdata driven to confirm outputs are masked.
        step();
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_wdata_ready", wdata_ready, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_done", done, 0);
        check("rst_mem_enable", mem_enable, 0);
        check("rst_mem_rw", mem_read_write, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1; wdata_valid = 1'b0; wdata = 8'h00;
        step();

        // Single write then read at address 3.
        start_req(1'b1, 4'h3, 4'h0);
        check("single_wr_req_busy", req_ready, 0);
        write_beat(4'h3, 8'hA5);
        finish_burst();
        check("single_wr_mem3", mem[3], 8'hA5);
        check("single_wr_done_cnt", done_count, 1);
        start_req(1'b0, 4'h3, 4'h0);
        read_beat(4'h3, 8'hA5);
        finish_burst();
        check("single_rd_done_cnt", done_count, 2);

        // Four-beat burst wrapping from E to 1.
        start_req(1'b1, 4'hE, 4'h3);
        write_beat(4'hE, 8'h11);
        write_beat(4'hF, 8'h22);
        write_beat(4'h0, 8'h33);
        write_beat(4'h1, 8'h44);
        finish_burst();
        check("wrap_memE", mem[14], 8'h11);
        check("wrap_memF", mem[15], 8'h22);
        check("wrap_mem0", mem[0], 8'h33);
        check("wrap_mem1", mem[1], 8'h44);
        start_req(1'b0, 4'hE, 4'h3);
        read_beat(4'hE, 8'h11);
        read_beat(4'hF, 8'h22);
        read_beat(4'h0, 8'h33);
        read_beat(4'h1, 8'h44);
        finish_burst();

        // Read backpressure: first beat held for 5 cycles.
        snap_rd = rd_count;
        start_req(1'b0, 4'hE, 4'h1);
        #1;
        check("bp_issue_addr", mem_addr, 4'hE);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_valid", rdata_valid, 1);
            check("bp_hold_data", rdata, 8'h11);
            check("bp_hold_enable", mem_enable, 0);
            step();
        end
        rdata_ready = 1'b1;
        #1;
        check("bp_release_data", rdata, 8'h11);
        step();
        rdata_ready = 1'b0;
        read_beat(4'hF, 8'h22);
        finish_burst();
        check("bp_mem_reads", rd_count - snap_rd, 2);

        // Write stalls: wdata_valid 1,0,0,1.
        snap_wr = wr_count;
        start_req(1'b1, 4'h8, 4'h1);
        write_beat(4'h8, 8'h5A);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall_enable", mem_enable, 0);
            check("stall_wready", wdata_ready, 0);
            check("stall_rw", mem_read_write, 1);
            step();
        end
        write_beat(4'h9, 8'hC3);
        finish_burst();
        check("stall_writes", wr_count - snap_wr, 2);
        check("stall_mem8", mem[8], 8'h5A);
        check("stall_mem9", mem[9], 8'hC3);

        // Reset during beat 2 of a 4-beat write.
        snap_wr = wr_count;
        snap_done = done_count;
        start_req(1'b1, 4'h4, 4'h3);
        write_beat(4'h4, 8'h61);
        write_beat(4'h5, 8'h62);
        wdata = 8'h63; wdata_valid = 1'b1; rst_n = 1'b0;
        #1;
        check("midrst_enable", mem_enable, 0);
        check("midrst_req_ready", req_ready, 1);
        step();
        rst_n = 1'b1; wdata_valid = 1'b0;
        #1;
        check("midrst_after_ready", req_ready, 1);
        check("midrst_after_done", done, 0);
        check("midrst_after_enable", mem_enable, 0);
        step();
        check("midrst_writes", wr_count - snap_wr, 2);
        check("midrst_mem4", mem[4], 8'h61);
        check("midrst_mem5", mem[5], 8'h62);
        check("midrst_mem6", mem[6], 8'h00);
        check("midrst_no_done", done_count - snap_done, 0);

        // Request held high while a read burst is busy.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h4; req_len = 4'h0;
        #1;
        check("busy_first_ready", req_ready, 1);
        step();
        req_write = 1'b1; req_addr = 4'hA; req_len = 4'h0;
        #1;
        check("busy_issue_ready", req_ready, 0);
        check("busy_issue_addr", mem_addr, 4'h4);
        step();
        check("busy_cap_ready", req_ready, 0);
        step();
        rdata_ready = 1'b1;
        #1;
        check("busy_out_ready", req_ready, 0);
        check("busy_out_data", rdata, 8'h61);
        step();
        rdata_ready = 1'b0;
        #1;
        check("busy_done_pulse", done, 1);
        check("busy_done_ready", req_ready, 0);
        step();
        check("busy_idle_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        write_beat(4'hA, 8'h77);
        finish_burst();
        check("busy_memA", mem[10], 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
